// File: rtl/fir_pkg.sv
// Shared widths and FIFO state encoding for the FIR output formatter.
package fir_pkg;

  localparam int unsigned FIR_IN_W  = 93;
  localparam int unsigned FIR_OUT_W = 12;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/fir_fmt_fifo.sv
// Output FIFO with occupancy-derived state, drop-on-full and a sticky overflow flag.
module fir_fmt_fifo
  import fir_pkg::*;
#(
  parameter int unsigned W     = FIR_OUT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_ready_i,
  input  logic         clr_i,
  output logic [W-1:0] rd_data_o,
  output logic         valid_o,
  output logic         ovf_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q;
  logic          ovf_q, ovf_d;
  logic          pop_c, wr_en_c;
  fifo_state_t   state_c;

  always_comb begin
    state_c = FIFO_PARTIAL;
    if (cnt_q == '0) begin
      state_c = FIFO_EMPTY;
    end else if (cnt_q == CW'(DEPTH)) begin
      state_c = FIFO_FULL;
    end
  end

  // A pop frees the slot a full-FIFO push needs; an empty FIFO never pops.
  always_comb begin
    pop_c   = (state_c != FIFO_EMPTY) && pop_ready_i;
    wr_en_c = push_i && ((state_c != FIFO_FULL) || pop_c);
    cnt_d   = cnt_q + CW'(wr_en_c) - CW'(pop_c);
    ovf_d   = ovf_q;
    if (push_i && !wr_en_c) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_c) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      ovf_q   <= ovf_d;
    end
  end

  assign rd_data_o = mem_q[rd_q];
  assign valid_o   = valid_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/fir_output_formatter.sv
// Decimate, round/shift and narrow FIR accumulator samples into an output FIFO.
// Define FIR_FMT_SAT_EN to saturate instead of wrapping when narrowing.
module fir_output_formatter
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = FIR_IN_W,
  parameter int unsigned OUT_W = FIR_OUT_W,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned DECIM = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_ovf,
  output logic                    ovf_sticky,
  output logic                    sat_flag
);

  localparam int unsigned DCW = 8;
  localparam logic signed [IN_W-1:0] RND = IN_W'(1) << (SHIFT - 1);

  logic [DCW-1:0]         dec_cnt_q, dec_cnt_d;
  logic signed [IN_W-1:0] sum_c, s1_d, s1_q;
  logic                   s1_vld_d, s1_vld_q;
  logic [OUT_W-1:0]       s2_d, s2_q;
  logic                   s2_vld_q;
  logic                   sat_d, sat_q;
  logic [OUT_W-1:0]       fifo_data;

  // Decimation count and stage-1 round-half-up shift
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    s1_vld_d  = 1'b0;
    sum_c     = in_data + RND;
    s1_d      = sum_c >>> SHIFT;
    if (in_valid) begin
      s1_vld_d  = (dec_cnt_q == '0);
      dec_cnt_d = (dec_cnt_q == DCW'(DECIM - 1)) ? '0 : dec_cnt_q + DCW'(1);
    end
  end

`ifdef FIR_FMT_SAT_EN
  localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    s2_d  = s1_q[OUT_W-1:0];
    sat_d = 1'b0;
    if (s1_q > SAT_MAX) begin
      s2_d  = OUT_W'(SAT_MAX);
      sat_d = s1_vld_q;
    end else if (s1_q < SAT_MIN) begin
      s2_d  = OUT_W'(SAT_MIN);
      sat_d = s1_vld_q;
    end
  end
`else
  logic unused_hi_c;

  // Narrowing wraps, so the bits above OUT_W are intentionally dropped.
  assign unused_hi_c = ^s1_q[IN_W-1:OUT_W];

  always_comb begin
    s2_d  = s1_q[OUT_W-1:0];
    sat_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt_q <= '0;
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      s2_q      <= '0;
      s2_vld_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      s1_q      <= s1_d;
      s1_vld_q  <= s1_vld_d;
      s2_q      <= s2_d;
      s2_vld_q  <= s1_vld_q;
      sat_q     <= sat_d;
    end
  end

  fir_fmt_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (s2_vld_q),
    .push_data_i (s2_q),
    .pop_ready_i (out_ready),
    .clr_i       (clr_ovf),
    .rd_data_o   (fifo_data),
    .valid_o     (out_valid),
    .ovf_o       (ovf_sticky)
  );

  assign out_data = fifo_data;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_fir_output_formatter.sv
// Randomised and directed checks of fir_output_formatter against a queue-based model.
module tb_fir_output_formatter;

  localparam int unsigned IN_W  = 93;
  localparam int unsigned OUT_W = 12;
  localparam int unsigned SHIFT = 8;
  localparam int unsigned DEPTH = 4;

`ifdef FIR_FMT_SAT_EN
  localparam logic signed [11:0] EXP_POS = 12'sd2047;
  localparam logic signed [11:0] EXP_NEG = -12'sd2048;
  localparam bit                 EXP_SAT = 1'b1;
`else
  localparam logic signed [11:0] EXP_POS = 12'sd904;
  localparam logic signed [11:0] EXP_NEG = -12'sd904;
  localparam bit                 EXP_SAT = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid, out_ready, clr_ovf;
  logic signed [OUT_W-1:0] out_data, out_data4;
  logic                    out_valid, out_valid4;
  logic                    ovf_sticky, ovf4, sat_flag, sat4;

  int tests_run    = 0;
  int tests_failed = 0;

  logic signed [11:0] mq[$];
  bit                 h1v, h2v, m_ovf, m_sat;
  longint             h1d, h2d;

  always #5 clk = ~clk;

  fir_output_formatter #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky), .sat_flag(sat_flag));

  fir_output_formatter #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(4), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .ovf_sticky(ovf4), .sat_flag(sat4));

  function automatic longint rnd_shift(input longint x);
    return (x + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
  endfunction

  function automatic logic signed [11:0] fmt(input longint x);
    longint r;
    r = rnd_shift(x);
`ifdef FIR_FMT_SAT_EN
    if (r > 2047) return 12'sd2047;
    if (r < -2048) return -12'sd2048;
`endif
    return 12'(r);
  endfunction

  function automatic bit clips(input longint x);
`ifdef FIR_FMT_SAT_EN
    longint r;
    r = rnd_shift(x);
    return (r > 2047) || (r < -2048);
`else
    return (x == 0) && (x != 0);
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    h1v = 0; h2v = 0; h1d = 0; h2d = 0; m_ovf = 0; m_sat = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit.
  task automatic tick(input bit v, input longint d, input bit rdy, input bit clr);
    bit pop, full;
    in_valid = v; in_data = IN_W'(d); out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    full = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (h2v && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (h2v && !(full && !pop)) mq.push_back(fmt(h2d));
    h2v = h1v; h2d = h1d; h1v = v; h1d = d;
    m_sat = h2v && clips(h2d);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; clr_ovf = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1; in_data = IN_W'(longint'(77 * 256)); out_ready = 1; clr_ovf = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (out_data !== 12'sd0) begin tests_failed++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
    tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
    tests_run++; if (out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid4 got=%b exp=0", out_valid4); end
    rst = 1'b0; in_valid = 0;
    model_clear();
  endtask

  task automatic test_rounding();
    reset_dut();
    tick(1, 'h300, 1, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL round_lat1 got=%b exp=0", out_valid); end
    tick(1, 'h2FF, 1, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL round_lat2 got=%b exp=0", out_valid); end
    tick(0, 0, 1, 0);
    tests_run++; if (out_valid !== 1'b1 || out_data !== 12'sd3) begin tests_failed++; $display("FAIL round_first got=%b/%0d exp=1/3", out_valid, out_data); end
    tick(0, 0, 1, 0);
    tests_run++; if (out_valid !== 1'b1 || out_data !== 12'sd3) begin tests_failed++; $display("FAIL round_second got=%b/%0d exp=1/3", out_valid, out_data); end
    tick(0, 0, 1, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL round_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    reset_dut();
    tick(1, 5000 * 256, 1, 0);
    tick(1, -(5000 * 256), 1, 0);
    tests_run++; if (sat_flag !== EXP_SAT) begin tests_failed++; $display("FAIL sat_pos_flag got=%b exp=%b", sat_flag, EXP_SAT); end
    tick(0, 0, 1, 0);
    tests_run++; if (out_valid !== 1'b1 || out_data !== EXP_POS) begin tests_failed++; $display("FAIL sat_pos_data got=%b/%0d exp=1/%0d", out_valid, out_data, EXP_POS); end
    tests_run++; if (sat_flag !== EXP_SAT) begin tests_failed++; $display("FAIL sat_neg_flag got=%b exp=%b", sat_flag, EXP_SAT); end
    tick(0, 0, 1, 0);
    tests_run++; if (out_valid !== 1'b1 || out_data !== EXP_NEG) begin tests_failed++; $display("FAIL sat_neg_data got=%b/%0d exp=1/%0d", out_valid, out_data, EXP_NEG); end
    tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL sat_pulse_end got=%b exp=0", sat_flag); end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 5; i++) tick(1, longint'(100 + i) * 256, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    tests_run++; if (ovf_sticky !== 1'b1 || m_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got=%b exp=1", ovf_sticky); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (out_valid !== 1'b1 || out_data !== 12'(100 + i)) begin tests_failed++; $display("FAIL ovf_order%0d got=%b/%0d exp=1/%0d", i, out_valid, out_data, 100 + i); end
      tick(0, 0, 1, 0);
    end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_dropped got=%b exp=0", out_valid); end
    tick(0, 0, 0, 1);
    tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got=%b exp=0", ovf_sticky); end
  endtask

  task automatic test_full_push_pop();
    int nxt;
    bit rdy;
    nxt = 0;
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      rdy = (i >= 6);
      if (out_valid && rdy) begin
        tests_run++; if (out_data !== 12'(200 + nxt)) begin tests_failed++; $display("FAIL fpp_order%0d got=%0d exp=%0d", nxt, out_data, 200 + nxt); end
        nxt++;
      end
      tick(i < 10, (i < 10) ? longint'(200 + i) * 256 : 0, rdy, 0);
      tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL fpp_ovf cyc%0d got=%b exp=0", i, ovf_sticky); end
    end
    tests_run++; if (nxt !== 10) begin tests_failed++; $display("FAIL fpp_count got=%0d exp=10", nxt); end
  endtask

  task automatic test_decim();
    logic signed [11:0] got[$];
    logic signed [11:0] exp[$];
    reset_dut();
    for (int i = 1; i <= 8; i++) begin
      if ((i - 1) % 4 == 0) exp.push_back(12'(i));
      tick(1, longint'(i) * 256, 1, 0);
      if (out_valid4) got.push_back(out_data4);
    end
    repeat (6) begin
      tick(0, 0, 1, 0);
      if (out_valid4) got.push_back(out_data4);
    end
    tests_run++; if (got.size() !== exp.size()) begin tests_failed++; $display("FAIL decim_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL decim_val%0d got=%0d exp=%0d", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic signed [11:0] got4[$];
    reset_dut();
    tick(1, 7 * 256, 0, 0);
    tick(1, 8 * 256, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_queued got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0 || out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid got=%b/%b exp=0/0", out_valid, out_valid4); end
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1, 9 * 256, 1, 0);
    repeat (5) begin
      tick(0, 0, 1, 0);
      if (out_valid4) got4.push_back(out_data4);
      tests_run++; if (out_valid !== (mq.size() > 0) || (mq.size() > 0 && out_data !== mq[0])) begin tests_failed++; $display("FAIL mid_stale got=%b/%0d exp_valid=%b", out_valid, out_data, mq.size() > 0); end
    end
    tests_run++; if (got4.size() !== 1 || (got4.size() == 1 && got4[0] !== 12'sd9)) begin tests_failed++; $display("FAIL mid_decim_restart got_n=%0d exp=1 sample 9", got4.size()); end
  endtask

  task automatic test_random();
    bit     v, rdy, clr;
    longint d;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      d   = longint'($urandom_range(0, 2 * 1048576)) - 1048576;
      tick(v, d, rdy, clr);
      tests_run++; if (out_valid !== (mq.size() > 0)) begin tests_failed++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", i, out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        tests_run++; if (out_data !== mq[0]) begin tests_failed++; $display("FAIL rnd_data cyc%0d got=%0d exp=%0d", i, out_data, mq[0]); end
      end
      tests_run++; if (ovf_sticky !== m_ovf) begin tests_failed++; $display("FAIL rnd_ovf cyc%0d got=%b exp=%b", i, ovf_sticky, m_ovf); end
      tests_run++; if (sat_flag !== m_sat) begin tests_failed++; $display("FAIL rnd_sat cyc%0d got=%b exp=%b", i, sat_flag, m_sat); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_decim();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
